// File: rtl/vga_frame_buffer.sv
// Ping-pong pixel memory feeding vga_from_mem: the producer fills the back bank,
// and the banks swap only on a vsync falling edge after a committed frame.
module vga_frame_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              vsync,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              front_sel,
    output logic              swap_pulse
);

    localparam int unsigned DEPTH = 32'd1 << (ADDR_W + 1);

    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              vsync_q;
    logic              front_sel_q, front_sel_d;
    logic              swap_pulse_q, swap_pulse_d;
    logic              wr_ready_q, wr_ready_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              vsync_fall;
    logic              wr_fire;

    assign vsync_fall = vsync_q & ~vsync;
    assign wr_fire    = wr_valid & wr_ready_q;

    // Commit on the last accepted word; swap on the first vsync falling edge after it.
    always_comb begin
        state_d      = state_q;
        front_sel_d  = front_sel_q;
        swap_pulse_d = 1'b0;
        case (state_q)
            FILL: begin
                if (wr_fire && wr_last) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (vsync_fall) begin
                    state_d      = FILL;
                    front_sel_d  = ~front_sel_q;
                    swap_pulse_d = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
        wr_ready_d = (state_d == FILL);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            vsync_q      <= 1'b1;
            front_sel_q  <= 1'b0;
            swap_pulse_q <= 1'b0;
            wr_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync;
            front_sel_q  <= front_sel_d;
            swap_pulse_q <= swap_pulse_d;
            wr_ready_q   <= wr_ready_d;
        end
    end

    // Storage is not reset; the upper address bit selects the bank.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem[{~front_sel_q, wr_addr}] <= wr_data;
        end
    end

    // Read uses the pre-swap front_sel, so the edge-cycle read still returns old-front data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[{front_sel_q, rd_addr}];
        end
    end

    assign rd_data    = rd_data_q;
    assign wr_ready   = wr_ready_q;
    assign front_sel  = front_sel_q;
    assign swap_pulse = swap_pulse_q;

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Bench for vga_frame_buffer: a frame/bank-level model is checked every cycle,
// alongside directed scenarios with literal expectations and a randomized phase.
module tb_vga_frame_buffer;

    logic       clock;
    logic       reset;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       vsync;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       front_sel;
    logic       swap_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    vga_frame_buffer #(.DATA_W(8), .ADDR_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .vsync      (vsync),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .front_sel  (front_sel),
        .swap_pulse (swap_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: two banks of words with known flags, which bank is shown,
    // whether a finished frame is waiting, and the last vsync level seen.
    logic [7:0] m_mem   [2][16];
    bit         m_known [2][16];
    bit         m_front   = 0;
    bit         m_waiting = 0;
    bit         m_vprev   = 1;
    bit         m_swap    = 0;
    logic [7:0] m_rd      = 8'h00;
    bit         m_rd_known = 0;

    always @(posedge clock or posedge reset) begin : model
        bit fall;
        if (reset) begin
            m_front    = 0;
            m_waiting  = 0;
            m_vprev    = 1;
            m_swap     = 0;
            m_rd       = 8'h00;
            m_rd_known = 1;
        end else begin
            fall       = m_vprev && !vsync;
            m_rd       = m_mem[m_front][rd_addr];
            m_rd_known = m_known[m_front][rd_addr];
            m_swap     = 0;
            if (!m_waiting) begin
                if (wr_valid) begin
                    m_mem[!m_front][wr_addr]   = wr_data;
                    m_known[!m_front][wr_addr] = 1;
                    if (wr_last) m_waiting = 1;
                end
            end else if (fall) begin
                m_front   = !m_front;
                m_waiting = 0;
                m_swap    = 1;
            end
            m_vprev = vsync;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            if (m_rd_known) check("model_rd_data", 32'(rd_data), 32'(m_rd));
            check("model_wr_ready",   32'(wr_ready),   32'(!m_waiting));
            check("model_front_sel",  32'(front_sel),  32'(m_front));
            check("model_swap_pulse", 32'(swap_pulse), 32'(m_swap));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [7:0] d, input logic last);
        int n = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_last  = last;
        while (!wr_ready && n < 100) begin
            tick();
            n++;
        end
        if (!wr_ready) check("write_timeout", 32'd1, 32'd0);
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic vsync_fall();
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
    endtask

    initial begin
        reset    = 1'b0;
        vsync    = 1'b1;
        rd_addr  = 4'd0;
        wr_valid = 1'b0;
        wr_addr  = 4'd0;
        wr_data  = 8'd0;
        wr_last  = 1'b0;

        // Reset applies asynchronously, before any clock edge.
        #3 reset = 1'b1;
        #1;
        check("rst_async_rd_data",   32'(rd_data),    32'd0);
        check("rst_async_wr_ready",  32'(wr_ready),   32'd1);
        check("rst_async_front_sel", 32'(front_sel),  32'd0);
        check("rst_async_swap",      32'(swap_pulse), 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_rd_data",   32'(rd_data),    32'd0);
        check("rst_wr_ready",  32'(wr_ready),   32'd1);
        check("rst_front_sel", 32'(front_sel),  32'd0);
        chk_en = 1;

        // Fill, commit, swap.
        for (int i = 0; i < 16; i++) write_word(4'(i), 8'(16 * i), i == 15);
        check("commit_wr_ready", 32'(wr_ready), 32'd0);
        vsync = 1'b0;
        tick();
        check("swap_front_sel", 32'(front_sel),  32'd1);
        check("swap_pulse_hi",  32'(swap_pulse), 32'd1);
        vsync = 1'b1;
        tick();
        check("swap_pulse_lo",  32'(swap_pulse), 32'd0);
        rd_addr = 4'd5;
        tick();
        check("read_addr5", 32'(rd_data), 32'd80);

        // Uncommitted frame: vsync edges must not swap.
        for (int i = 0; i < 8; i++) write_word(4'($urandom), 8'($urandom_range(0, 127)), 1'b0);
        vsync_fall();
        vsync_fall();
        check("nocommit_front_sel", 32'(front_sel), 32'd1);
        check("nocommit_wr_ready",  32'(wr_ready),  32'd1);

        // Back-pressure while a committed frame waits.
        write_word(4'd9, 8'h33, 1'b1);
        wr_valid = 1'b1;
        wr_addr  = 4'd7;
        wr_data  = 8'hAA;
        wr_last  = 1'b0;
        repeat (20) tick();
        check("bp_wr_ready", 32'(wr_ready), 32'd0);
        vsync = 1'b0;
        tick();
        check("bp_swap_front", 32'(front_sel), 32'd0);
        check("bp_ready_back", 32'(wr_ready),  32'd1);
        tick();
        wr_valid = 1'b0;
        vsync    = 1'b1;
        rd_addr  = 4'd7;
        tick();
        check("bp_front_not_aa", 32'(rd_data === 8'hAA), 32'd0);
        write_word(4'd0, 8'h44, 1'b1);
        vsync_fall();
        rd_addr = 4'd7;
        tick();
        check("bp_aa_landed", 32'(rd_data), 32'hAA);

        // wr_last coincident with a vsync falling edge.
        write_word(4'd3, 8'h11, 1'b0);
        write_word(4'd1, 8'h55, 1'b0);
        wr_valid = 1'b1;
        wr_addr  = 4'd2;
        wr_data  = 8'h66;
        wr_last  = 1'b1;
        vsync    = 1'b0;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        check("coinc_front_sel", 32'(front_sel),  32'd1);
        check("coinc_no_swap",   32'(swap_pulse), 32'd0);
        check("coinc_pending",   32'(wr_ready),   32'd0);
        vsync = 1'b1;
        repeat (2) tick();
        check("coinc_still_front", 32'(front_sel), 32'd1);
        vsync = 1'b0;
        tick();
        check("coinc_next_swap",  32'(front_sel),  32'd0);
        check("coinc_next_pulse", 32'(swap_pulse), 32'd1);
        vsync = 1'b1;
        tick();

        // Read held across the swap edge.
        write_word(4'd3, 8'h22, 1'b1);
        rd_addr = 4'd3;
        repeat (2) tick();
        vsync = 1'b0;
        tick();
        check("edge_read_old", 32'(rd_data),   32'h11);
        check("edge_front",    32'(front_sel), 32'd1);
        vsync = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_edge_read_new", 32'(rd_data), 32'h22);
        end

        // Randomized traffic with a mid-frame reset.
        for (int c = 0; c < 600; c++) begin
            wr_valid = ($urandom_range(0, 2) != 0);
            wr_addr  = 4'($urandom);
            wr_data  = 8'($urandom);
            wr_last  = ($urandom_range(0, 7) == 0);
            rd_addr  = 4'($urandom);
            if ($urandom_range(0, 4) == 0) vsync = ~vsync;
            if (c == 400) begin
                #2 reset = 1'b1;
                #1;
                check("midrst_front_sel", 32'(front_sel), 32'd0);
                check("midrst_wr_ready",  32'(wr_ready),  32'd1);
                #1 reset = 1'b0;
            end
            tick();
        end

        wr_valid = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
